seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 4..32).
REQ-002 SHALL have parameter DIV_CYCLES, default WIDTH, number of iterative divide steps (fixed equal to WIDTH; read-only).
REQ-003 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand/opcode valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept an operation.
REQ-007 SHALL have port a, input, WIDTH, first operand, unsigned.
REQ-008 SHALL have port b, input, WIDTH, second operand, unsigned.
REQ-009 SHALL have port sel, input, 2, opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port result, output, 2*WIDTH, operation result.
REQ-013 SHALL have port carry, output, 1, add carry-out / sub borrow.
REQ-014 SHALL have port zero, output, 1, result equals 0.
REQ-015 SHALL have port dz_err, output, 1, divide-by-zero or unsupported op.

Function
REQ-016 SHALL implement FSM states IDLE, DIV, DONE.
REQ-017 SHALL drive in_ready high only in IDLE; an op is accepted on a clock edge where in_valid and in_ready are both high.
REQ-018 SHALL latch a, b, sel on acceptance; later input changes have no effect on the op in flight.
REQ-019 SHALL, for add/sub/mul, transition IDLE->DONE on acceptance; out_valid goes high in the next cycle (1-cycle latency).
REQ-020 SHALL, for add, give result[WIDTH-1:0]=a+b mod 2^WIDTH, carry=bit WIDTH of the sum, upper bits 0.
REQ-021 SHALL, for sub, give result[WIDTH-1:0]=a-b mod 2^WIDTH, carry=1 when a<b, upper bits 0.
REQ-022 SHALL, for mul, give full 2*WIDTH product, carry=0.
REQ-023 SHALL, for div with b!=0, go IDLE->DIV, run WIDTH restoring-division steps (one per cycle), then DIV->DONE; out_valid high WIDTH+1 cycles after acceptance.
REQ-024 SHALL, for div, give result[WIDTH-1:0]=quotient and result[2*WIDTH-1:WIDTH]=remainder, carry=0.
REQ-025 SHALL, for div with b==0, go IDLE->DONE directly with quotient all ones, remainder=a, dz_err=1.
REQ-026 SHALL compute zero over all 2*WIDTH result bits; dz_err=0 for every non-error case.
REQ-027 SHALL hold result, carry, zero, dz_err and out_valid stable in DONE until out_valid&&out_ready, then go DONE->IDLE.
REQ-028 SHALL keep result/flags at their last value in IDLE and DIV; they are valid only while out_valid is high.
REQ-029 SHALL NOT accept a new op in DONE even when out_ready is high that cycle; the next acceptance is no earlier than the following cycle.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force state IDLE, out_valid=0, result=0, carry=0, zero=0, dz_err=0, internal divider registers 0.
REQ-031 SHALL abort any op in DIV or DONE on reset, with no result delivered; in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-032 SHALL include the iterative divider and DIV state only when macro SEQ_ALU_DIV_EN is defined.
REQ-033 SHALL, without SEQ_ALU_DIV_EN, complete sel=11 in 1 cycle via IDLE->DONE with result=0, zero=1, dz_err=1, carry=0; other ops are unchanged.

Verification (WIDTH=8)
REQ-034 SHALL test add: a=200, b=100, sel=00 -> next cycle out_valid=1, result=0x002C, carry=1, zero=0.
REQ-035 SHALL test sub: a=5, b=7, sel=01 -> result=0x00FE, carry=1; then a=7, b=7 -> result=0, zero=1, carry=0.
REQ-036 SHALL test mul: a=255, b=255, sel=10 -> result=0xFE01, 1-cycle latency.
REQ-037 SHALL test div: a=200, b=7, sel=11 -> out_valid exactly 9 cycles after acceptance, result=0x041C (rem 4, quot 28), in_ready=0 throughout; with b=0 -> result=0xC8FF, dz_err=1 after 1 cycle.
REQ-038 SHALL test backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-039 SHALL test reset: assert rst_n low 3 cycles into a div -> all outputs 0 immediately and no out_valid afterward; with SEQ_ALU_DIV_EN undefined, sel=11 -> dz_err=1, zero=1.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential add/sub/mul/div ALU with valid/ready handshakes on both sides.
// Define SEQ_ALU_DIV_EN to build the iterative restoring divider and its DIV state.
module seq_alu #(
  parameter  int WIDTH      = 8,
  localparam int DIV_CYCLES = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 dz_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd1
`ifdef SEQ_ALU_DIV_EN
    , DIV = 2'd2
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 dz_q, dz_d;

  logic [WIDTH:0]       sum, diff;
  logic [2*WIDTH-1:0]   prod;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

`ifdef SEQ_ALU_DIV_EN
  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   shifted, trial;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign dz_err    = dz_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    dz_d     = dz_q;
`ifdef SEQ_ALU_DIV_EN
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
          carry_d = 1'b0;
          dz_d    = 1'b0;
          unique case (sel)
            2'b00: begin
              result_d = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
              carry_d  = sum[WIDTH];
            end
            2'b01: begin
              result_d = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
              carry_d  = diff[WIDTH];
            end
            2'b10: result_d = prod;
            default: begin
`ifdef SEQ_ALU_DIV_EN
              if (b == '0) begin
                result_d = {a, {WIDTH{1'b1}}};
                dz_d     = 1'b1;
              end else begin
                // Flags and result keep their old values until the quotient is ready.
                state_d = DIV;
                carry_d = carry_q;
                dz_d    = dz_q;
                quot_d  = a;
                rem_d   = '0;
                dvsr_d  = b;
                cnt_d   = '0;
              end
`else
              result_d = '0;
              dz_d     = 1'b1;
`endif
            end
          endcase
          if (state_d == DONE) zero_d = (result_d == '0);
        end
      end
`ifdef SEQ_ALU_DIV_EN
      DIV: begin
        if (cnt_q == CW'(DIV_CYCLES)) begin
          state_d  = DONE;
          result_d = {rem_q, quot_q};
          carry_d  = 1'b0;
          dz_d     = 1'b0;
          zero_d   = ({rem_q, quot_q} == '0);
        end else begin
          if (!trial[WIDTH]) begin
            rem_d  = trial[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = shifted[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
`ifdef SEQ_ALU_DIV_EN
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed cases plus random ops
// compared with an arithmetic reference model; follows SEQ_ALU_DIV_EN like the RTL.
module tb_seq_alu;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     sel = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           carry;
  logic           zero;
  logic           dz_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .dz_err(dz_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] res;
    logic           c;
    logic           z;
    logic           dz;
    int             lat;
  } exp_t;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [1:0] ms);
    exp_t   e;
    longint ua  = longint'(ma);
    longint ub  = longint'(mb);
    longint mod = longint'(1) << W;
    longint r   = 0;
    e.c = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (ms)
      2'd0: begin r = (ua + ub) % mod; e.c = (ua + ub) >= mod; end
      2'd1: begin r = (ua - ub + mod) % mod; e.c = (ua < ub); end
      2'd2: r = ua * ub;
      default: begin
`ifdef SEQ_ALU_DIV_EN
        if (ub == 0) begin r = ua * mod + (mod - 1); e.dz = 1'b1; end
        else begin r = (ua % ub) * mod + (ua / ub); e.lat = W + 1; end
`else
        r = 0; e.dz = 1'b1;
`endif
      end
    endcase
    e.res = r[2*W-1:0];
    e.z   = (r == 0);
    return e;
  endfunction

  // Issue one op, measure latency, check outputs, optionally stall, then drain.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                       input logic [1:0] ts, input int hold, input string name);
    exp_t e;
    int   lat;
    bit   busy_ok, stable_ok;
    e = model(ta, tb2, ts);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready before issue got=%b exp=1", name, in_ready);
    else pass_cnt++;
    a = ta; b = tb2; sel = ts; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); sel = 2'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 64) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++;
    if (lat !== e.lat) $display("FAIL %s latency got=%0d exp=%0d", name, lat, e.lat);
    else pass_cnt++;
    if (e.lat > 1) begin
      total_cnt++;
      if (!busy_ok) $display("FAIL %s in_ready while busy got=1 exp=0", name);
      else pass_cnt++;
    end
    total_cnt++;
    if (result !== e.res) $display("FAIL %s result got=%h exp=%h", name, result, e.res);
    else pass_cnt++;
    total_cnt++;
    if ({carry, zero, dz_err} !== {e.c, e.z, e.dz})
      $display("FAIL %s flags c/z/dz got=%b%b%b exp=%b%b%b", name, carry, zero, dz_err, e.c, e.z, e.dz);
    else pass_cnt++;
    if (hold > 0) begin
      stable_ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res ||
            {carry, zero, dz_err} !== {e.c, e.z, e.dz}) stable_ok = 1'b0;
      end
      total_cnt++;
      if (!stable_ok) $display("FAIL %s stall stability got=unstable exp=stable", name);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s drain out_valid/in_ready got=%b%b exp=01", name, out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({out_valid, result, carry, zero, dz_err} !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_state got=v%b r%h c%b z%b dz%b rdy%b exp=all 0, rdy 1",
               out_valid, result, carry, zero, dz_err, in_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    do_op(8'd200, 8'd100, 2'b00, 0, "add_200_100");
    do_op(8'd0,   8'd0,   2'b00, 0, "add_zero");
  endtask

  task automatic test_sub();
    do_op(8'd5, 8'd7, 2'b01, 0, "sub_5_7");
    do_op(8'd7, 8'd7, 2'b01, 0, "sub_7_7");
  endtask

  task automatic test_mul();
    do_op(8'd255, 8'd255, 2'b10, 0, "mul_255_255");
  endtask

  task automatic test_div();
    do_op(8'd200, 8'd7, 2'b11, 0, "div_200_7");
    do_op(8'd200, 8'd0, 2'b11, 0, "div_200_0");
    do_op(8'd3,   8'd9, 2'b11, 0, "div_small");
  endtask

  task automatic test_backpressure();
    do_op(8'd77, 8'd99, 2'b00, 5, "bp_add");
    do_op(8'd250, 8'd13, 2'b11, 5, "bp_div");
  endtask

  // in_valid stays high through DONE: the held op must only be taken from IDLE.
  task automatic test_no_accept_in_done();
    exp_t e2;
    e2 = model(8'd9, 8'd11, 2'b10);
    a = 8'd1; b = 8'd2; sel = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 8'd9; b = 8'd11; sel = 2'b10;
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL no_accept_in_done got=v%b rdy%b exp=v0 rdy1", out_valid, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || result !== e2.res)
      $display("FAIL next_after_done got=v%b r%h exp=v1 r%h", out_valid, result, e2.res);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic [1:0]   rs;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      rs = 2'($urandom);
      do_op(ra, rb, rs, $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
`ifdef SEQ_ALU_DIV_EN
    a = 8'd200; b = 8'd7; sel = 2'b11;
`else
    a = 8'd200; b = 8'd100; sel = 2'b00;
`endif
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, result, carry, zero, dz_err} !== '0)
      $display("FAIL reset_abort outputs got=v%b r%h c%b z%b dz%b exp=all 0",
               out_valid, result, carry, zero, dz_err);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_release in_ready got=%b exp=1", in_ready);
    else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    out_ready = 1'b0;
    total_cnt++;
    if (seen) $display("FAIL reset_no_result out_valid got=1 exp=0");
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_backpressure();
    test_no_accept_in_done();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
